// File: rtl/bullet_ctrl.sv
// Tank bullet engine: launches on fire, steps once per frame, flags brick pixels
// under the bullet for erasure, and draws the bullet / explosion overlay.
module bullet_ctrl #(
   parameter int COLOR_BITS     = 24,
   parameter int H_ACTIVE       = 640,
   parameter int V_ACTIVE       = 480,
   parameter int TANK_SIZE      = 32,
   parameter int BULLET_SIZE    = 4,
   parameter int SPEED          = 4,
   parameter int EXPLODE_SIZE   = 16,
   parameter int EXPLODE_FRAMES = 8,
   parameter logic [COLOR_BITS-1:0] BULLET_COLOR  = 24'hFFFFFF,
   parameter logic [COLOR_BITS-1:0] EXPLODE_COLOR = 24'h00A5FF
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    fire_i,
   input  logic [9:0]              tank_x_i,
   input  logic [9:0]              tank_y_i,
   input  logic [1:0]              tank_dir_i,
   input  logic                    display_enable_i,
   input  logic [9:0]              hpos_i,
   input  logic [9:0]              vpos_i,
   input  logic                    all_hard_block_i,
   input  logic                    destroyable_block_i,
   output logic                    bullet_collide_o,
   output logic                    bullet_active_o,
   output logic                    bullet_enable_o,
   output logic [COLOR_BITS/3-1:0] bullet_blue_o,
   output logic [COLOR_BITS/3-1:0] bullet_green_o,
   output logic [COLOR_BITS/3-1:0] bullet_red_o
);
   localparam int CW = COLOR_BITS/3;
   localparam int EW = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
   localparam logic [10:0] VA   = 11'(V_ACTIVE);
   localparam logic [10:0] BS1  = 11'(BULLET_SIZE-1);
   localparam logic [10:0] ES1  = 11'(EXPLODE_SIZE-1);
   localparam logic [10:0] EOFF = 11'(EXPLODE_SIZE/2 - BULLET_SIZE/2);
   localparam logic [10:0] SPD  = 11'(SPEED);
   localparam logic [10:0] HLIM = 11'(H_ACTIVE-BULLET_SIZE);
   localparam logic [10:0] VLIM = 11'(V_ACTIVE-BULLET_SIZE);
   localparam logic [9:0]  LOFF = 10'(TANK_SIZE/2 - BULLET_SIZE/2);

   typedef enum logic [1:0] {IDLE, FLYING, EXPLODE} state_t;

   state_t          state;
   logic [9:0]      bx, by;
   logic [1:0]      dir;
   logic            hit_flag, fire_pend, vsync_q;
   logic [EW-1:0]   exp_cnt;

   logic [10:0] h11, v11, bx11, by11;
   logic        ft, in_box, in_exp, hit_pix;
   logic [COLOR_BITS-1:0] pix;

   assign h11  = {1'b0, hpos_i};
   assign v11  = {1'b0, vpos_i};
   assign bx11 = {1'b0, bx};
   assign by11 = {1'b0, by};
   assign ft   = (v11 == VA) && !vsync_q;

   assign in_box = (state == FLYING) &&
                   (h11 >= bx11) && (h11 <= bx11 + BS1) &&
                   (v11 >= by11) && (v11 <= by11 + BS1);
   // Explosion box origin may sit left/above zero, so compare with the offset
   // moved onto the pixel side instead of subtracting from bx/by.
   assign in_exp = (state == EXPLODE) &&
                   (h11 + EOFF >= bx11) && (h11 + EOFF <= bx11 + ES1) &&
                   (v11 + EOFF >= by11) && (v11 + EOFF <= by11 + ES1);

   assign hit_pix          = in_box && display_enable_i && all_hard_block_i;
   assign bullet_collide_o = in_box && display_enable_i && destroyable_block_i;
   assign bullet_enable_o  = display_enable_i && (in_box || in_exp);

   always_comb begin
      pix = '0;
      if (in_box)      pix = BULLET_COLOR;
      else if (in_exp) pix = EXPLODE_COLOR;
   end
   assign bullet_blue_o  = pix[3*CW-1:2*CW];
   assign bullet_green_o = pix[2*CW-1:CW];
   assign bullet_red_o   = pix[CW-1:0];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state           <= IDLE;
         bx              <= '0;
         by              <= '0;
         dir             <= '0;
         hit_flag        <= 1'b0;
         fire_pend       <= 1'b0;
         exp_cnt         <= '0;
         vsync_q         <= 1'b0;
         bullet_active_o <= 1'b0;
      end else begin
         vsync_q <= (v11 == VA);
         case (state)
            IDLE: begin
               if (ft && (fire_pend || fire_i)) begin
                  dir             <= tank_dir_i;
                  bx              <= tank_x_i + LOFF;
                  by              <= tank_y_i + LOFF;
                  fire_pend       <= 1'b0;
                  hit_flag        <= 1'b0;
                  state           <= FLYING;
                  bullet_active_o <= 1'b1;
               end else if (fire_i) begin
                  fire_pend <= 1'b1;
               end
            end
            FLYING: begin
               if (ft) begin
                  hit_flag <= 1'b0;
                  // A hit seen anywhere in the frame beats the boundary check.
                  if (hit_flag || hit_pix) begin
                     state   <= EXPLODE;
                     exp_cnt <= EW'(EXPLODE_FRAMES-1);
                  end else begin
                     case (dir)
                        2'b00: if (by11 < SPD) begin state <= IDLE; bullet_active_o <= 1'b0; end
                               else by <= by - 10'(SPEED);
                        2'b01: if (bx11 + SPD > HLIM) begin state <= IDLE; bullet_active_o <= 1'b0; end
                               else bx <= bx + 10'(SPEED);
                        2'b10: if (by11 + SPD > VLIM) begin state <= IDLE; bullet_active_o <= 1'b0; end
                               else by <= by + 10'(SPEED);
                        default: if (bx11 < SPD) begin state <= IDLE; bullet_active_o <= 1'b0; end
                                 else bx <= bx - 10'(SPEED);
                     endcase
                  end
               end else if (hit_pix) begin
                  hit_flag <= 1'b1;
               end
            end
            EXPLODE: begin
               if (ft) begin
                  if (exp_cnt == '0) begin
                     state           <= IDLE;
                     bullet_active_o <= 1'b0;
                  end else begin
                     exp_cnt <= exp_cnt - 1'b1;
                  end
               end
            end
            default: begin
               state           <= IDLE;
               bullet_active_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed scoreboard bench for bullet_ctrl: expected values queued with the
// stimulus and popped at each observation point.
module tb_bullet_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1, fire = 1'b0, de = 1'b0, hard = 1'b0, dstr = 1'b0;
   logic [9:0] tx = '0, ty = '0, hpos = '0, vpos = '0;
   logic [1:0] tdir = '0;
   logic       collide, active, en;
   logic [7:0] blue, green, red;

   logic [31:0] exp_q[$];
   int compared = 0, mismatched = 0;

   bullet_ctrl dut (
      .clk_i(clk), .reset_i(reset), .fire_i(fire),
      .tank_x_i(tx), .tank_y_i(ty), .tank_dir_i(tdir),
      .display_enable_i(de), .hpos_i(hpos), .vpos_i(vpos),
      .all_hard_block_i(hard), .destroyable_block_i(dstr),
      .bullet_collide_o(collide), .bullet_active_o(active), .bullet_enable_o(en),
      .bullet_blue_o(blue), .bullet_green_o(green), .bullet_red_o(red)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic expect_v(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         mismatched++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
         return;
      end
      e = exp_q.pop_front();
      compared++;
      assert (obs === e) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   task automatic frame();
      de = 0; hard = 0; dstr = 0; hpos = '0;
      vpos = 10'd480; tick();
      vpos = 10'd0;   tick();
   endtask

   task automatic probe(input int x, input int y, input logic d, input logic h);
      hpos = 10'(x); vpos = 10'(y); de = 1; dstr = d; hard = h; #1;
   endtask

   task automatic clr();
      de = 0; dstr = 0; hard = 0; hpos = '0; vpos = '0; #1;
   endtask

   task automatic launch(input int x, input int y, input logic [1:0] d);
      tx = 10'(x); ty = 10'(y); tdir = d;
      fire = 1; tick(); fire = 0;
      frame();
   endtask

   // Expected overlay hit and colour at a probed pixel, from a bench-side box model.
   task automatic chk_pix(input string tag, input int x, input int y,
                          input int bx, input int by, input logic exploding);
      logic inb;
      logic [23:0] col;
      probe(x, y, 0, 0);
      if (exploding)
         inb = (x >= bx - 6) && (x <= bx + 9) && (y >= by - 6) && (y <= by + 9);
      else
         inb = (x >= bx) && (x <= bx + 3) && (y >= by) && (y <= by + 3);
      col = !inb ? 24'h0 : (exploding ? 24'h00A5FF : 24'hFFFFFF);
      expect_v({31'd0, inb});        chk({tag, ".en"}, {31'd0, en});
      expect_v({8'd0, col});         chk({tag, ".rgb"}, {8'd0, blue, green, red});
      clr();
   endtask

   initial begin
      int bx, by;
      // reset
      tick(); tick(); reset = 0; tick();
      expect_v(0); chk("rst.active", {31'd0, active});
      probe(0, 0, 1, 1);
      expect_v(0); chk("rst.collide", {31'd0, collide});
      expect_v(0); chk("rst.en", {31'd0, en});
      clr();

      // launch upward from (224,416): pending until the frame tick
      tx = 10'd224; ty = 10'd416; tdir = 2'b00;
      fire = 1; tick(); fire = 0; tick();
      expect_v(0); chk("pend.active", {31'd0, active});
      frame();
      bx = 238; by = 430;
      expect_v(1); chk("launch.active", {31'd0, active});
      chk_pix("launch.in", 238, 430, bx, by, 0);
      chk_pix("launch.right", 242, 430, bx, by, 0);
      frame();
      by = by - 4;
      chk_pix("move.tl", 238, 426, bx, by, 0);
      chk_pix("move.br", 241, 429, bx, by, 0);
      chk_pix("move.old", 238, 430, bx, by, 0);
      chk_pix("move.left", 237, 426, bx, by, 0);

      // reset mid-flight aborts
      reset = 1; tick(); reset = 0;
      expect_v(0); chk("abort.active", {31'd0, active});
      probe(238, 426, 1, 1);
      expect_v(0); chk("abort.collide", {31'd0, collide});
      expect_v(0); chk("abort.en", {31'd0, en});
      clr();
      frame();
      expect_v(0); chk("abort.norelaunch", {31'd0, active});

      // brick at (240,300): erase on the same clock, then explode 8 frames
      launch(224, 286, 2'b00);
      bx = 238; by = 300;
      probe(240, 300, 1, 1);
      expect_v(1); chk("brick.collide", {31'd0, collide});
      tick(); clr();
      probe(240, 300, 0, 0);
      expect_v(0); chk("brick.gone", {31'd0, collide});
      clr();
      frame();
      expect_v(1); chk("exp.active", {31'd0, active});
      chk_pix("exp.ctr", 240, 300, bx, by, 1);
      chk_pix("exp.tl", 232, 294, bx, by, 1);
      chk_pix("exp.xl", 231, 294, bx, by, 1);
      chk_pix("exp.br", 247, 309, bx, by, 1);
      chk_pix("exp.xr", 248, 309, bx, by, 1);
      probe(240, 300, 1, 1);
      expect_v(0); chk("exp.nocollide", {31'd0, collide});
      clr();
      fire = 1; tick(); fire = 0;
      for (int i = 0; i < 7; i++) frame();
      expect_v(1); chk("exp.frame7", {31'd0, active});
      frame();
      expect_v(0); chk("exp.done", {31'd0, active});
      frame();
      expect_v(0); chk("exp.firedropped", {31'd0, active});

      // wall at the right edge: hit beats boundary
      launch(620, 100, 2'b01);
      bx = 634; by = 114;
      probe(634, 114, 0, 1);
      expect_v(0); chk("wall.collide", {31'd0, collide});
      tick(); clr();
      frame();
      expect_v(1); chk("wall.active", {31'd0, active});
      chk_pix("wall.exp", 636, 116, bx, by, 1);
      for (int i = 0; i < 8; i++) frame();
      expect_v(0); chk("wall.done", {31'd0, active});

      // leftward to the border, fire during flight ignored
      launch(0, 200, 2'b11);
      bx = 14; by = 214;
      fire = 1; tick(); fire = 0;
      for (int i = 0; i < 3; i++) begin frame(); bx = bx - 4; end
      expect_v(1); chk("left.fly", {31'd0, active});
      chk_pix("left.pos", 2, 214, bx, by, 0);
      frame();
      expect_v(0); chk("left.idle", {31'd0, active});
      frame();
      expect_v(0); chk("left.norelaunch", {31'd0, active});

      // fire on the same clock as the frame tick
      tx = 10'd224; ty = 10'd416; tdir = 2'b00;
      fire = 1; vpos = 10'd480; tick();
      fire = 0; vpos = 10'd0; tick();
      expect_v(1); chk("samefire.active", {31'd0, active});
      chk_pix("samefire.pos", 238, 430, 238, 430, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
